hbridge_sequencer: RTL and testbench

Arbitrates motion requests from the push-buttons and slide switches and sequences the two-motor H-bridge outputs. Every direction change passes through a programmable dead-time with all bridge legs off, so a leg is never reversed while still driven. Drive is PWM-gated. Sits between the board inputs and the hbridge pins and replaces direct button-to-bridge wiring. Its motiondir output feeds the LED display.

---
 rtl/hbridge_sequencer_pkg.sv | 50 +++++
 rtl/hbridge_sequencer_if.sv | 25 ++
 rtl/hbridge_sequencer_pwm_gen.sv | 35 +++
 rtl/hbridge_sequencer.sv | 140 ++++++++++++++
 tb/tb_hbridge_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/hbridge_sequencer_pkg.sv
// motion_pkg: shared types for the H-bridge sequencer.
//   dir_t        - decoded motion request / latched target direction
//   seq_state_t  - sequencer FSM states
//   pins_t       - the four bridge leg drives
//   dir_onehot() - motiondir LED encoding
//   dir_pins()   - bridge leg pattern per direction
package motion_pkg;

  typedef enum logic [2:0] {STOP, FWD, REV, LEFT, RIGHT} dir_t;

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} seq_state_t;

  typedef struct packed {
    logic b1a;
    logic b2a;
    logic b1b;
    logic b2b;
  } pins_t;

  localparam logic [3:0] MD_STOP  = 4'b0000;
  localparam logic [3:0] MD_FWD   = 4'b0001;
  localparam logic [3:0] MD_REV   = 4'b0010;
  localparam logic [3:0] MD_LEFT  = 4'b0100;
  localparam logic [3:0] MD_RIGHT = 4'b1000;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    case (d)
      FWD:     return MD_FWD;
      REV:     return MD_REV;
      LEFT:    return MD_LEFT;
      RIGHT:   return MD_RIGHT;
      default: return MD_STOP;
    endcase
  endfunction

  // Motor A: fwd=1a rev=2a. Motor B: fwd=1b rev=2b. Turns run the motors opposed.
  function automatic pins_t dir_pins(input dir_t d);
    pins_t p;
    p = '0;
    case (d)
      FWD:     begin p.b1a = 1'b1; p.b1b = 1'b1; end
      REV:     begin p.b2a = 1'b1; p.b2b = 1'b1; end
      LEFT:    begin p.b2a = 1'b1; p.b1b = 1'b1; end
      RIGHT:   begin p.b1a = 1'b1; p.b2b = 1'b1; end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hbridge_sequencer_if.sv
// Board-side bundle of the H-bridge sequencer.
//   btnU/D/L/R, sw[3:0] : raw asynchronous motion requests
//   duty[7:0]           : PWM on-time per period
//   bridge1a/2a/1b/2b   : bridge leg drives
//   motiondir[3:0]      : one-hot direction for the LEDs
//   busy                : dead-time in progress
// master drives the requests, slave is the sequencer.
interface hbridge_sequencer_if;
  logic       btnU, btnD, btnL, btnR;
  logic [3:0] sw;
  logic [7:0] duty;
  logic       bridge1a, bridge2a, bridge1b, bridge2b;
  logic [3:0] motiondir;
  logic       busy;

  modport master (
    output btnU, btnD, btnL, btnR, sw, duty,
    input  bridge1a, bridge2a, bridge1b, bridge2b, motiondir, busy
  );

  modport slave (
    input  btnU, btnD, btnL, btnR, sw, duty,
    output bridge1a, bridge2a, bridge1b, bridge2b, motiondir, busy
  );
endinterface

// File: rtl/hbridge_sequencer_pwm_gen.sv
// pwm_gen: free-running PWM counter 0..PWM_PERIOD-1 with a duty register
// that only reloads on wrap, so a period is never cut short or stretched.
//   clk, rst     : clock, async active-high reset
//   i_duty[7:0]  : requested on-time
//   o_pwm_on_nxt : pwm_on as it will be after the coming edge; the sequencer
//                  registers its pins from this so they line up with cnt.
module pwm_gen
  #(parameter int PWM_PERIOD = 256)
  (input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_duty,
   output logic       o_pwm_on_nxt);

  localparam int CW = $clog2(PWM_PERIOD);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_duty_q, w_duty_nxt;

  assign w_cnt_nxt  = (r_cnt == CW'(PWM_PERIOD - 1)) ? '0 : r_cnt + CW'(1);
  assign w_duty_nxt = (w_cnt_nxt == '0) ? i_duty : r_duty_q;

  // 9-bit compare: duty >= PWM_PERIOD is simply always on.
  assign o_pwm_on_nxt = ({{(9-CW){1'b0}}, w_cnt_nxt} < {1'b0, w_duty_nxt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty_q <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_duty_q <= w_duty_nxt;
    end
  end

endmodule

// File: rtl/hbridge_sequencer.sv
// hbridge_sequencer: arbitrates button/switch motion requests and sequences
// the two-motor H-bridge with a dead-time (all legs off) between any two
// driven directions. Drive pins are PWM gated.
//   clk, rst : clock, async active-high reset (pins forced low at once)
//   bus      : hbridge_sequencer_if.slave (requests, duty, pins, motiondir, busy)
// Outputs are registered from next-state so pins move on the state edge.
module hbridge_sequencer
  import motion_pkg::*;
  #(parameter int DEAD_CYCLES = 1000,
    parameter int PWM_PERIOD  = 256)
  (input  logic clk,
   input  logic rst,
   hbridge_sequencer_if.slave bus);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  // {sw[3:0], btnR, btnL, btnD, btnU}
  logic [7:0] w_raw, r_sync1, r_sync2;
  dir_t       w_req;

  seq_state_t r_state, w_state_nxt;
  dir_t       r_target, w_target_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt;

  pins_t      r_pins, w_pins_nxt;
  logic [3:0] r_md, w_md_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_pwm_on_nxt;

  assign w_raw = {bus.sw, bus.btnR, bus.btnL, bus.btnD, bus.btnU};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Buttons override switches entirely; fixed priority within each group.
  always_comb begin
    w_req = STOP;
    if (|r_sync2[3:0]) begin
      if      (r_sync2[0]) w_req = FWD;
      else if (r_sync2[1]) w_req = REV;
      else if (r_sync2[2]) w_req = LEFT;
      else                 w_req = RIGHT;
    end else if (|r_sync2[7:4]) begin
      if      (r_sync2[4]) w_req = FWD;
      else if (r_sync2[5]) w_req = REV;
      else if (r_sync2[6]) w_req = LEFT;
      else                 w_req = RIGHT;
    end
  end

  pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
    .clk          (clk),
    .rst          (rst),
    .i_duty       (bus.duty),
    .o_pwm_on_nxt (w_pwm_on_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= STOP;
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_dcnt   <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_dcnt_nxt   = r_dcnt;
    case (r_state)
      IDLE: if (w_req != STOP) begin
        w_target_nxt = w_req;
        w_dcnt_nxt   = DEAD_LOAD;
        w_state_nxt  = DEAD;
      end
      DEAD: begin
        // Retargeting inside the dead window keeps the running count:
        // the legs are already off, so the elapsed time still counts.
        if (w_req == STOP) begin
          w_state_nxt = IDLE;
        end else begin
          w_target_nxt = w_req;
          if (r_dcnt == '0) w_state_nxt = DRIVE;
          else              w_dcnt_nxt  = r_dcnt - DW'(1);
        end
      end
      DRIVE: begin
        if (w_req == STOP) begin
          w_state_nxt = IDLE;
        end else if (w_req != r_target) begin
          w_target_nxt = w_req;
          w_dcnt_nxt   = DEAD_LOAD;
          w_state_nxt  = DEAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pins_nxt = '0;
    w_md_nxt   = MD_STOP;
    w_busy_nxt = 1'b0;
    if (w_state_nxt != IDLE) w_md_nxt = dir_onehot(w_target_nxt);
    if (w_state_nxt == DEAD) w_busy_nxt = 1'b1;
    if (w_state_nxt == DRIVE && w_pwm_on_nxt) w_pins_nxt = dir_pins(w_target_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pins <= '0;
      r_md   <= '0;
      r_busy <= 1'b0;
    end else begin
      r_pins <= w_pins_nxt;
      r_md   <= w_md_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.bridge1a  = r_pins.b1a;
  assign bus.bridge2a  = r_pins.b2a;
  assign bus.bridge1b  = r_pins.b1b;
  assign bus.bridge2b  = r_pins.b2b;
  assign bus.motiondir = r_md;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Directed bench for hbridge_sequencer at DEAD_CYCLES=4, PWM_PERIOD=8.
// Pins are viewed as {2b,1b,2a,1a}: FWD=0101 REV=1010 LEFT=0110 RIGHT=1001.
// "Edge N" counts posedges after the one at which an input was changed.
module tb_hbridge_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  hbridge_sequencer_if bus ();

  hbridge_sequencer #(.DEAD_CYCLES(4), .PWM_PERIOD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the PWM counter phase modulo 8.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  logic [3:0] pins;
  assign pins = {bus.bridge2b, bus.bridge1b, bus.bridge2a, bus.bridge1a};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] p, input logic [3:0] md, input logic b);
    chk({tag, ".pins"}, 8'(pins), 8'(p));
    chk({tag, ".md"},   8'(bus.motiondir), 8'(md));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(b));
  endtask

  task automatic clr_in();
    bus.btnU = 1'b0; bus.btnD = 1'b0; bus.btnL = 1'b0; bus.btnR = 1'b0;
    bus.sw   = 4'b0000;
  endtask

  initial begin
    clr_in();
    bus.duty = 8'd255;
    rst = 1'b1;
    #12;
    chk_out("reset", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick(10);
    chk_out("idle", 4'b0000, 4'b0000, 1'b0);

    // Basic latency: DEAD at edge 3, DRIVE at edge 7.
    bus.btnU = 1'b1;
    tick(3);  chk_out("fwd_e3", 4'b0000, 4'b0001, 1'b1);
    for (int e = 4; e <= 6; e++) begin
      tick(1); chk_out("fwd_dead", 4'b0000, 4'b0001, 1'b1);
    end
    tick(1);  chk_out("fwd_e7", 4'b0101, 4'b0001, 1'b0);

    // Reversal: exactly 4 all-off cycles, never a shoot-through leg pair.
    tick(2);
    bus.btnU = 1'b0; bus.btnD = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("no_shoot", 8'((bus.bridge1a & bus.bridge2a) | (bus.bridge1b & bus.bridge2b)), 8'd0);
      if (e <= 2)      chk_out("rev_pre",  4'b0101, 4'b0001, 1'b0);
      else if (e <= 6) chk_out("rev_dead", 4'b0000, 4'b0010, 1'b1);
      else             chk_out("rev_e7",   4'b1010, 4'b0010, 1'b0);
    end

    // Priority: buttons beat switches.
    bus.btnD = 1'b0; bus.btnU = 1'b1; bus.sw = 4'b0010;
    tick(3); chk_out("prio_u_sw", 4'b0000, 4'b0001, 1'b1);
    tick(4); chk_out("prio_u_drv", 4'b0101, 4'b0001, 1'b0);
    clr_in(); bus.btnL = 1'b1; bus.btnR = 1'b1;
    tick(3); chk_out("prio_lr", 4'b0000, 4'b0100, 1'b1);
    tick(4); chk_out("prio_lr_drv", 4'b0110, 4'b0100, 1'b0);
    // Switch 1100 decodes to LEFT too: same target, no new dead-time.
    clr_in(); bus.sw = 4'b1100;
    tick(4); chk_out("prio_sw", 4'b0110, 4'b0100, 1'b0);
    clr_in();
    tick(2); chk_out("stop_e2", 4'b0110, 4'b0100, 1'b0);
    tick(1); chk_out("stop_e3", 4'b0000, 4'b0000, 1'b0);

    // PWM at duty 3, then 6 changed mid-period, then 0.
    bus.duty = 8'd3; bus.btnU = 1'b1;
    tick(7); chk("pwm_md", 8'(bus.motiondir), 8'h01);
    for (int i = 0; i < 8 && (cyc % 8) != 0; i++) tick(1);
    chk("pwm_align", 8'(cyc % 8), 8'd0);
    for (int k = 0; k < 8; k++) begin
      chk("pwm_d3_1a", 8'(bus.bridge1a), 8'(k < 3));
      chk("pwm_d3_1b", 8'(bus.bridge1b), 8'(k < 3));
      if (k == 4) bus.duty = 8'd6;
      tick(1);
    end
    for (int k = 0; k < 8; k++) begin
      chk("pwm_d6_1a", 8'(bus.bridge1a), 8'(k < 6));
      if (k == 4) bus.duty = 8'd0;
      tick(1);
    end
    for (int k = 0; k < 8; k++) begin
      chk("pwm_d0_pins", 8'(pins), 8'h0);
      chk("pwm_d0_md", 8'(bus.motiondir), 8'h01);
      tick(1);
    end

    // Retarget inside DEAD keeps the original deadline.
    bus.duty = 8'd255;
    tick(8); chk_out("rt_fwd", 4'b0101, 4'b0001, 1'b0);
    bus.btnU = 1'b0; bus.btnD = 1'b1;
    tick(2); bus.btnD = 1'b0; bus.btnL = 1'b1;
    tick(1); chk_out("rt_e3", 4'b0000, 4'b0010, 1'b1);
    tick(2); chk_out("rt_e5", 4'b0000, 4'b0100, 1'b1);
    tick(1); chk_out("rt_e6", 4'b0000, 4'b0100, 1'b1);
    tick(1); chk_out("rt_e7", 4'b0110, 4'b0100, 1'b0);

    // Request change landing exactly on counter==0 is taken into DRIVE.
    bus.btnL = 1'b0; bus.btnU = 1'b1;
    tick(3); chk_out("sim_e3", 4'b0000, 4'b0001, 1'b1);
    tick(1); bus.btnU = 1'b0; bus.btnR = 1'b1;
    tick(2); chk_out("sim_e6", 4'b0000, 4'b0001, 1'b1);
    tick(1); chk_out("sim_e7", 4'b1001, 4'b1000, 1'b0);

    // Release during DEAD returns to IDLE with no drive pulse.
    bus.btnR = 1'b0; bus.btnD = 1'b1;
    tick(3); chk_out("rel_e3", 4'b0000, 4'b0010, 1'b1);
    bus.btnD = 1'b0;
    tick(2); chk_out("rel_e5", 4'b0000, 4'b0010, 1'b1);
    for (int e = 6; e <= 9; e++) begin
      tick(1); chk_out("rel_idle", 4'b0000, 4'b0000, 1'b0);
    end

    // Async reset mid-DRIVE, then full latency again after release.
    bus.btnU = 1'b1;
    tick(7); chk_out("rs_drv", 4'b0101, 4'b0001, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("rs_async", 4'b0000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    chk_out("rs_hold", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick(3); chk_out("rs_e3", 4'b0000, 4'b0001, 1'b1);
    tick(3); chk_out("rs_e6", 4'b0000, 4'b0001, 1'b1);
    // duty register was cleared by reset and reloads on the wrap at edge 8.
    tick(1); chk_out("rs_e7", 4'b0000, 4'b0001, 1'b0);
    tick(1); chk_out("rs_e8", 4'b0101, 4'b0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
